// File: rtl/instr_exec_reader.sv
// Read-side engine: walks a run of instruction register entries, executes each opcode and
// streams the signed 64-bit results. Optional writeback port under `INSTR_WRITEBACK_EN`.
package instr_register_pkg;
   localparam logic [3:0] ZERO  = 4'd0;
   localparam logic [3:0] PASSA = 4'd1;
   localparam logic [3:0] PASSB = 4'd2;
   localparam logic [3:0] ADD   = 4'd3;
   localparam logic [3:0] SUB   = 4'd4;
   localparam logic [3:0] MULT  = 4'd5;
   localparam logic [3:0] DIV   = 4'd6;
   localparam logic [3:0] MOD   = 4'd7;

   typedef struct packed {
      logic [3:0]         opc;
      logic signed [31:0] op_a;
      logic signed [31:0] op_b;
   } instruction_t;
endpackage

module instr_exec_reader
   import instr_register_pkg::*;
#(
   parameter int                 ADDR_W   = 5,
   parameter int                 CNT_W    = 6,
   parameter logic signed [63:0] DIV0_VAL = 64'sd0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   first_addr,
   input  logic [CNT_W-1:0]    count,
   output logic [ADDR_W-1:0]   rd_addr,
   input  instruction_t        rd_instr,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [ADDR_W-1:0]   res_addr,
   output logic [3:0]          res_opc,
   output logic signed [63:0]  result,
   output logic                div0,
   output logic                illegal,
   output logic                busy,
   output logic                done
`ifdef INSTR_WRITEBACK_EN
   ,
   output logic                wb_en,
   output logic [ADDR_W-1:0]   wb_addr,
   output logic signed [63:0]  wb_result
`endif
);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   rem;
   instruction_t       instr_q;

   logic signed [63:0] a, b, exec_res;
   logic               exec_div0, exec_ill;

   // Operands are widened before the op so MULT is full-width and -2**31/-1 cannot overflow.
   always_comb begin
      a         = {{32{instr_q.op_a[31]}}, instr_q.op_a};
      b         = {{32{instr_q.op_b[31]}}, instr_q.op_b};
      exec_res  = '0;
      exec_div0 = 1'b0;
      exec_ill  = 1'b0;
      case (instr_q.opc)
         ZERO:  exec_res = '0;
         PASSA: exec_res = a;
         PASSB: exec_res = b;
         ADD:   exec_res = a + b;
         SUB:   exec_res = a - b;
         MULT:  exec_res = a * b;
         DIV, MOD: begin
            if (b == 64'sd0) begin
               exec_res  = DIV0_VAL;
               exec_div0 = 1'b1;
            end else if (instr_q.opc == DIV) begin
               exec_res = a / b;
            end else begin
               exec_res = a % b;
            end
         end
         default: exec_ill = 1'b1;
      endcase
   end

   wire handshake = (state == OUT) && res_valid && res_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rem       <= '0;
         instr_q   <= '0;
         rd_addr   <= '0;
         res_valid <= 1'b0;
         res_addr  <= '0;
         res_opc   <= '0;
         result    <= '0;
         div0      <= 1'b0;
         illegal   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy <= 1'b1;
               if (count != '0) begin
                  rd_addr <= first_addr;
                  rem     <= count;
                  state   <= FETCH;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            FETCH: begin
               instr_q <= rd_instr;
               state   <= EXEC;
            end
            EXEC: begin
               result    <= exec_res;
               div0      <= exec_div0;
               illegal   <= exec_ill;
               res_addr  <= rd_addr;
               res_opc   <= instr_q.opc;
               res_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: if (res_ready) begin
               res_valid <= 1'b0;
               rem       <= rem - 1'b1;
               if (rem == 1) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
                  state   <= FETCH;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INSTR_WRITEBACK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_en     <= 1'b0;
         wb_addr   <= '0;
         wb_result <= '0;
      end else begin
         wb_en <= handshake;
         if (handshake) begin
            wb_addr   <= res_addr;
            wb_result <= result;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_exec_reader.sv
// Randomized bench for instr_exec_reader: scoreboard of expected results from a plain
// arithmetic model, handshake/hold checks every cycle, plus literal anchors for the model.
module tb_instr_exec_reader;
   import instr_register_pkg::*;

   localparam logic [63:0] D0V = 64'h0000_0000_dead_beef;

   logic               clk = 1'b0;
   logic               reset, start, res_ready;
   logic [4:0]         first_addr, rd_addr, res_addr;
   logic [5:0]         count;
   instruction_t       rd_instr;
   logic               res_valid, div0, illegal, busy, done;
   logic [3:0]         res_opc;
   logic signed [63:0] result;
`ifdef INSTR_WRITEBACK_EN
   logic               wb_en;
   logic [4:0]         wb_addr;
   logic signed [63:0] wb_result;
`endif

   instruction_t mem [32];
   assign rd_instr = mem[rd_addr];

   always #5 clk = ~clk;

   instr_exec_reader #(.ADDR_W(5), .CNT_W(6), .DIV0_VAL(D0V)) dut (
      .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .count(count),
      .rd_addr(rd_addr), .rd_instr(rd_instr), .res_valid(res_valid), .res_ready(res_ready),
      .res_addr(res_addr), .res_opc(res_opc), .result(result), .div0(div0),
      .illegal(illegal), .busy(busy), .done(done)
`ifdef INSTR_WRITEBACK_EN
      , .wb_en(wb_en), .wb_addr(wb_addr), .wb_result(wb_result)
`endif
   );

   int compared = 0, mismatched = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the opcode definitions, using 64-bit integers.
   task automatic model(input instruction_t i, output logic [63:0] r, output bit d0, output bit il);
      longint x, y;
      x = i.op_a; y = i.op_b; r = 0; d0 = 0; il = 0;
      case (i.opc)
         4'd0: r = 0;
         4'd1: r = x;
         4'd2: r = y;
         4'd3: r = x + y;
         4'd4: r = x - y;
         4'd5: r = x * y;
         4'd6: if (y == 0) begin r = D0V; d0 = 1; end else r = x / y;
         4'd7: if (y == 0) begin r = D0V; d0 = 1; end else r = x % y;
         default: il = 1;
      endcase
   endtask

   typedef struct { logic [4:0] addr; instruction_t ins; } exp_t;
   exp_t        sbq[$];
   logic [63:0] log_res [32];
   bit          log_d0 [32], log_il [32];
   int          hs_addr[$];
   int          done_cnt = 0;

   bit          hold_prev = 0;
   logic [63:0] s_res;
   logic [4:0]  s_addr, s_rd;
   logic [3:0]  s_opc;
   logic        s_d0, s_il;
`ifdef INSTR_WRITEBACK_EN
   bit          wb_pend = 0;
   logic [4:0]  wb_ea;
   logic [63:0] wb_er;
`endif

   always @(negedge clk) begin
      if (reset) begin
         hold_prev = 0;
`ifdef INSTR_WRITEBACK_EN
         wb_pend = 0;
`endif
      end else begin
`ifdef INSTR_WRITEBACK_EN
         chk("wb_en", wb_en, wb_pend);
         if (wb_pend) begin
            chk("wb_addr", wb_addr, wb_ea);
            chk("wb_result", wb_result, wb_er);
         end
         wb_pend = 0;
`endif
         if (hold_prev) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_result", result, s_res);
            chk("hold_res_addr", res_addr, s_addr);
            chk("hold_rd_addr", rd_addr, s_rd);
            chk("hold_flags", {res_opc, div0, illegal}, {s_opc, s_d0, s_il});
         end
         hold_prev = 0;
         if (res_valid) begin
            if (!res_ready) begin
               hold_prev = 1;
               s_res = result; s_addr = res_addr; s_rd = rd_addr;
               s_opc = res_opc; s_d0 = div0; s_il = illegal;
            end else if (sbq.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_result: got addr %0d, expected no result", res_addr);
            end else begin
               exp_t e; logic [63:0] r; bit d, il;
               e = sbq.pop_front();
               model(e.ins, r, d, il);
               chk("res_addr", res_addr, e.addr);
               chk("res_opc", res_opc, e.ins.opc);
               chk("result", result, r);
               chk("div0_illegal", {div0, illegal}, {d, il});
               log_res[res_addr] = result; log_d0[res_addr] = div0; log_il[res_addr] = illegal;
               hs_addr.push_back(int'(res_addr));
`ifdef INSTR_WRITEBACK_EN
               wb_pend = 1; wb_ea = res_addr; wb_er = result;
`endif
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_addrs"}, {rd_addr, res_addr, res_opc}, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_ctl"}, {res_valid, div0, illegal, busy, done}, 0);
   endtask

   task automatic run(input int fa, input int cnt);
      first_addr = 5'(fa); count = 6'(cnt); start = 1;
      for (int i = 0; i < cnt; i++) begin
         exp_t e;
         e.addr = 5'((fa + i) % 32);
         e.ins  = mem[e.addr];
         sbq.push_back(e);
      end
      @(posedge clk); #1; start = 0;
   endtask

   task automatic wait_done(input bit rnd, input int budget);
      bit seen = 0;
      for (int k = 0; k < budget; k++) begin
         if (done) begin seen = 1; break; end
         @(posedge clk); #1;
         if (rnd) res_ready = 1'($urandom_range(0, 1));
      end
      if (!seen) begin
         compared++; mismatched++;
         $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
      end
      @(posedge clk); #1;
      chk("sb_drained", sbq.size(), 0);
      sbq.delete();
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hffff_ffff;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] r; bit d, il; int lat, dc; logic [4:0] ra;
      for (int i = 0; i < 32; i++) mem[i] = '{opc: 4'($urandom_range(0, 15)), op_a: rnd_op(), op_b: rnd_op()};
      reset = 1; start = 0; first_addr = 0; count = 0; res_ready = 1;
      repeat (3) @(posedge clk); #1;
      chk_zero("reset");
      reset = 0;
      @(posedge clk); #1;

      // literal anchors for the model
      model('{opc: ADD, op_a: 32'sd5, op_b: -32'sd7}, r, d, il);
      chk("model_add", r, 64'hffff_ffff_ffff_fffe);
      model('{opc: MULT, op_a: 32'h7fffffff, op_b: 32'h7fffffff}, r, d, il);
      chk("model_mult", r, 64'h3fff_ffff_0000_0001);
      model('{opc: DIV, op_a: -32'sd7, op_b: 32'sd2}, r, d, il);
      chk("model_div", r, 64'hffff_ffff_ffff_fffd);
      model('{opc: MOD, op_a: -32'sd7, op_b: 32'sd2}, r, d, il);
      chk("model_mod", r, 64'hffff_ffff_ffff_ffff);
      model('{opc: DIV, op_a: 32'sd10, op_b: 32'sd0}, r, d, il);
      chk("model_div0", {r, 7'd0, d}, {D0V, 8'd1});

      // single ADD run: latency and result
      mem[0] = '{opc: ADD, op_a: 32'sd5, op_b: -32'sd7};
      dc = done_cnt;
      first_addr = 0; count = 1; start = 1;
      sbq.push_back('{addr: 5'd0, ins: mem[0]});
      lat = 0;
      do begin @(posedge clk); #1; start = 0; lat++; end while (!res_valid && lat < 10);
      chk("latency", lat, 3);
      wait_done(0, 20);
      chk("add_result", log_res[0], 64'hffff_ffff_ffff_fffe);
      chk("add_done_pulses", done_cnt - dc, 1);

      // arithmetic corner cases
      mem[2] = '{opc: MULT, op_a: 32'h7fffffff, op_b: 32'h7fffffff};
      mem[3] = '{opc: DIV,  op_a: -32'sd7, op_b: 32'sd2};
      mem[4] = '{opc: MOD,  op_a: -32'sd7, op_b: 32'sd2};
      mem[5] = '{opc: DIV,  op_a: 32'sd10, op_b: 32'sd0};
      mem[6] = '{opc: 4'hc, op_a: 32'sd3, op_b: 32'sd4};
      mem[7] = '{opc: DIV,  op_a: 32'h8000_0000, op_b: -32'sd1};
      run(2, 6);
      wait_done(0, 60);
      chk("mult_lit", log_res[2], 64'h3fff_ffff_0000_0001);
      chk("div_lit", log_res[3], 64'hffff_ffff_ffff_fffd);
      chk("mod_lit", log_res[4], 64'hffff_ffff_ffff_ffff);
      chk("div0_lit", {log_res[5], 7'd0, log_d0[5]}, {D0V, 8'd1});
      chk("illegal_lit", {log_res[6], 7'd0, log_il[6]}, {64'd0, 8'd1});
      chk("minint_div_lit", log_res[7], 64'h0000_0000_8000_0000);

      // address wrap
      hs_addr.delete(); dc = done_cnt;
      run(30, 4);
      wait_done(0, 40);
      chk("wrap_n", hs_addr.size(), 4);
      if (hs_addr.size() == 4)
         chk("wrap_order", {8'(hs_addr[0]), 8'(hs_addr[1]), 8'(hs_addr[2]), 8'(hs_addr[3])}, {8'd30, 8'd31, 8'd0, 8'd1});
      chk("wrap_done_pulses", done_cnt - dc, 1);

      // zero-length run
      dc = done_cnt;
      run(5, 0);
      wait_done(0, 10);
      chk("cnt0_done_pulses", done_cnt - dc, 1);

      // backpressure with a start pulse while busy
      res_ready = 0;
      run(10, 2);
      lat = 0;
      while (!res_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      chk("bp_valid", res_valid, 1);
      ra = rd_addr;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin start = 1; first_addr = 20; count = 3; end
         if (k == 2) start = 0;
      end
      chk("bp_rd_addr", rd_addr, ra);
      chk("bp_res_addr", res_addr, 10);
      chk("bp_busy", busy, 1);
      res_ready = 1;
      wait_done(0, 40);

      // reset during EXEC aborts the run
      dc = done_cnt;
      first_addr = 0; count = 3; start = 1;
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1;
      reset = 1; #1;
      chk_zero("reset_exec");
      sbq.delete();
      @(posedge clk); #1; reset = 0;
      repeat (8) @(posedge clk); #1;
      chk("abort_no_done", done_cnt - dc, 0);
      chk("abort_idle", {busy, res_valid}, 0);

      // randomized runs with random backpressure
      for (int t = 0; t < 25; t++) begin
         int fa, cnt;
         for (int i = 0; i < 32; i++) mem[i] = '{opc: 4'($urandom_range(0, 15)), op_a: rnd_op(), op_b: rnd_op()};
         fa  = $urandom_range(0, 31);
         cnt = ($urandom_range(0, 7) == 0) ? 32 : $urandom_range(0, 10);
         dc  = done_cnt;
         run(fa, cnt);
         wait_done(1, cnt * 40 + 20);
         chk("rand_done_pulses", done_cnt - dc, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
